// File: rtl/comb_delay_ctrl_pkg.sv
// Shared FSM encoding and arithmetic helpers for the comb delay sequencer.
package comb_delay_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_CALC = 3'd3,
    S_WR   = 3'd4,
    S_DONE = 3'd5
  } state_e;

  // Clamp a signed value into the two's complement range of a w-bit word.
  function automatic logic signed [31:0] sat_s(input logic signed [31:0] s,
                                               input int unsigned         w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/comb_delay_ram.sv
// Single-port synchronous-read delay-line memory, no reset, BRAM friendly.
module comb_delay_ram #(
  parameter int unsigned WIDTH  = 12,
  parameter int unsigned DEPTH  = 8192,
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk_i,
  input  logic              re_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/comb_delay_ctrl.sv
// Walks NUM_CH feedback combs per frame over one shared delay RAM:
// read delayed sample, y = sat(x + g*d), write back, advance circular pointer.
module comb_delay_ctrl
  import comb_delay_ctrl_pkg::*;
#(
  parameter  int unsigned WIDTH   = 12,
  parameter  int unsigned NUM_CH  = 4,
  parameter  int unsigned MAX_LEN = 2048,
  parameter  int unsigned GAIN_W  = 8,
  localparam int unsigned LEN_W   = $clog2(MAX_LEN),
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned FRAME_W = NUM_CH * WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FRAME_W-1:0] in_frame,
  output logic               out_valid,
  output logic [FRAME_W-1:0] out_frame,
  output logic               busy,
  input  logic               cfg_we,
  output logic               cfg_ready,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [LEN_W:0]     cfg_delay,
  input  logic [GAIN_W-1:0]  cfg_gain
);

  localparam int unsigned ADDR_W = CH_W + LEN_W;
  localparam int unsigned PROD_W = WIDTH + GAIN_W + 1;
  localparam int unsigned FB_W   = WIDTH + 1;
  localparam int unsigned SUM_W  = WIDTH + 2;
  localparam int unsigned DLY_W  = LEN_W + 1;

  state_e                        state_q, state_d;
  logic [CH_W-1:0]               ch_q, ch_d;
  logic [FRAME_W-1:0]            x_q, x_d;
  logic [FRAME_W-1:0]            out_frame_q, out_frame_d;
  logic [NUM_CH-1:0][DLY_W-1:0]  delay_q, delay_d;
  logic [NUM_CH-1:0][GAIN_W-1:0] gain_q, gain_d;
  logic [NUM_CH-1:0][LEN_W-1:0]  ptr_q, ptr_d;
  logic [NUM_CH-1:0]             filled_q, filled_d;

  logic                    ram_re_c;
  logic                    ram_we_c;
  logic [ADDR_W-1:0]       ram_addr_c;
  logic [WIDTH-1:0]        ram_rdata;
  logic [WIDTH-1:0]        y_wr_c;
  logic [DLY_W-1:0]        cfg_delay_c;
  logic signed [WIDTH-1:0] x_c, d_c, y_c;
  logic signed [PROD_W-1:0] p_c;
  logic signed [FB_W-1:0]  f_c;
  logic signed [SUM_W-1:0] s_c;

  // Legal delays are 1..MAX_LEN frames.
  always_comb begin
    cfg_delay_c = cfg_delay;
    if (cfg_delay == '0) cfg_delay_c = DLY_W'(1);
    else if (cfg_delay > DLY_W'(MAX_LEN)) cfg_delay_c = DLY_W'(MAX_LEN);
  end

  assign ram_addr_c = {ch_q, ptr_q[ch_q]};
  assign y_wr_c     = out_frame_q[ch_q*WIDTH +: WIDTH];

  // Unfilled lines read as silence so stale RAM never leaks into the output.
  always_comb begin
    x_c = x_q[ch_q*WIDTH +: WIDTH];
    d_c = filled_q[ch_q] ? ram_rdata : '0;
    p_c = PROD_W'(d_c) * PROD_W'($signed({1'b0, gain_q[ch_q]}));
    f_c = FB_W'(p_c >>> GAIN_W);
    s_c = SUM_W'(x_c) + SUM_W'(f_c);
    y_c = WIDTH'(sat_s(32'(s_c), WIDTH));
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    x_d         = x_q;
    out_frame_d = out_frame_q;
    delay_d     = delay_q;
    gain_d      = gain_q;
    ptr_d       = ptr_q;
    filled_d    = filled_q;
    ram_re_c    = 1'b0;
    ram_we_c    = 1'b0;
    if (enable) begin
      case (state_q)
        S_IDLE: begin
          if (cfg_we) begin
            gain_d[cfg_ch]   = cfg_gain;
            delay_d[cfg_ch]  = cfg_delay_c;
            ptr_d[cfg_ch]    = '0;
            filled_d[cfg_ch] = 1'b0;
          end
          if (in_valid) begin
            x_d     = in_frame;
            ch_d    = '0;
            state_d = S_RD;
          end
        end
        S_RD: begin
          ram_re_c = 1'b1;
          state_d  = S_WAIT;
        end
        S_WAIT: state_d = S_CALC;
        S_CALC: begin
          out_frame_d[ch_q*WIDTH +: WIDTH] = y_c;
          state_d = S_WR;
        end
        S_WR: begin
          ram_we_c = 1'b1;
          if ({1'b0, ptr_q[ch_q]} == delay_q[ch_q] - DLY_W'(1)) begin
            ptr_d[ch_q]    = '0;
            filled_d[ch_q] = 1'b1;
          end else begin
            ptr_d[ch_q] = ptr_q[ch_q] + LEN_W'(1);
          end
          if (ch_q == CH_W'(NUM_CH - 1)) begin
            state_d = S_DONE;
          end else begin
            ch_d    = ch_q + CH_W'(1);
            state_d = S_RD;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      x_q         <= '0;
      out_frame_q <= '0;
      delay_q     <= {NUM_CH{DLY_W'(MAX_LEN)}};
      gain_q      <= '0;
      ptr_q       <= '0;
      filled_q    <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      x_q         <= x_d;
      out_frame_q <= out_frame_d;
      delay_q     <= delay_d;
      gain_q      <= gain_d;
      ptr_q       <= ptr_d;
      filled_q    <= filled_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign cfg_ready = in_ready;
  assign busy      = ~in_ready;
  assign out_valid = (state_q == S_DONE) & enable;
  assign out_frame = out_frame_q;

  comb_delay_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (NUM_CH * MAX_LEN),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .re_i    (ram_re_c),
    .we_i    (ram_we_c),
    .addr_i  (ram_addr_c),
    .wdata_i (y_wr_c),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_comb_delay_ctrl.sv
// Directed scoreboard bench for comb_delay_ctrl with a reference comb model.
module tb_comb_delay_ctrl;
  localparam int unsigned WIDTH   = 12;
  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned MAX_LEN = 2048;
  localparam int unsigned GAIN_W  = 8;
  localparam int unsigned FW      = NUM_CH * WIDTH;

  logic          clk = 1'b0;
  logic          reset, enable, in_valid, in_ready, out_valid, busy;
  logic          cfg_we, cfg_ready;
  logic [FW-1:0] in_frame, out_frame;
  logic [1:0]    cfg_ch;
  logic [11:0]   cfg_delay;
  logic [7:0]    cfg_gain;

  int errors = 0;
  int checks = 0;
  logic [FW-1:0] sb[$];
  int md[NUM_CH];
  int mg[NUM_CH];
  int mcnt[NUM_CH];
  int ring[NUM_CH][MAX_LEN];
  int echo[10] = '{1000, 0, 0, 500, 0, 0, 250, 0, 0, 125};

  always #5 clk = ~clk;

  comb_delay_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .in_frame(in_frame), .out_valid(out_valid), .out_frame(out_frame), .busy(busy),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay),
    .cfg_gain(cfg_gain)
  );

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] pk(input int a, input int b, input int c, input int d);
    logic [WIDTH-1:0] s0, s1, s2, s3;
    s0 = WIDTH'(a); s1 = WIDTH'(b); s2 = WIDTH'(c); s3 = WIDTH'(d);
    return {s3, s2, s1, s0};
  endfunction

  function automatic int sl(input logic [FW-1:0] f, input int c);
    logic signed [WIDTH-1:0] v;
    v = f[c*WIDTH +: WIDTH];
    return int'(v);
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      md[c] = MAX_LEN; mg[c] = 0; mcnt[c] = 0;
    end
  endtask

  task automatic m_cfg(input int c, input int d, input int g);
    md[c]   = (d < 1) ? 1 : ((d > MAX_LEN) ? MAX_LEN : d);
    mg[c]   = g;
    mcnt[c] = 0;
  endtask

  // Reference: y[n] = sat(x[n] + floor(g*y[n-D]/2^GAIN_W)), silence before D outputs exist.
  task automatic m_frame(input logic [FW-1:0] fr, output logic [FW-1:0] e);
    e = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      int x, d, y;
      x = sl(fr, c);
      d = (mcnt[c] >= md[c]) ? ring[c][(mcnt[c] - md[c]) % MAX_LEN] : 0;
      y = x + ((d * mg[c]) >>> GAIN_W);
      if (y > 2047) y = 2047;
      if (y < -2048) y = -2048;
      ring[c][mcnt[c] % MAX_LEN] = y;
      mcnt[c]++;
      e[c*WIDTH +: WIDTH] = WIDTH'(y);
    end
  endtask

  task automatic cfg(input int c, input int d, input int g);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_ch = 2'(c); cfg_delay = 12'(d); cfg_gain = 8'(g);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_cfg(c, d, g);
  endtask

  // wc: 0 none, 1 config on the accept edge, 2 config pulse while busy (must be ignored)
  task automatic send(input logic [FW-1:0] fr, input int stall_at, input int stall_len,
                      input int wc, input int wch, input int wd, input int wg, input string tag);
    logic [FW-1:0] e;
    int n;
    bit seen;
    if (wc == 1) m_cfg(wch, wd, wg);
    m_frame(fr, e);
    sb.push_back(e);
    @(posedge clk); #1;
    in_frame = fr; in_valid = 1'b1;
    if (wc == 1) begin
      cfg_we = 1'b1; cfg_ch = 2'(wch); cfg_delay = 12'(wd); cfg_gain = 8'(wg);
    end
    chk({tag, " ready"}, FW'(in_ready), FW'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (stall_len > 0 && n == stall_at) enable = 1'b0;
      if (stall_len > 0 && n == stall_at + stall_len) enable = 1'b1;
      if (wc == 2 && n == 5) begin
        cfg_we = 1'b1; cfg_ch = 2'(wch); cfg_delay = 12'(wd); cfg_gain = 8'(wg);
      end
      if (wc == 2 && n == 6) cfg_we = 1'b0;
      if (out_valid) seen = 1'b1;
    end
    chk({tag, " latency"}, FW'(n), FW'(17 + stall_len));
    chk({tag, " frame"}, out_frame, sb.pop_front());
  endtask

  task automatic sendf(input logic [FW-1:0] fr, input string tag);
    send(fr, 0, 0, 0, 0, 0, 0, tag);
  endtask

  initial begin
    int n, acc_t, nout, viol;
    bit have_acc;
    logic [FW-1:0] e;
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; in_frame = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_delay = '0; cfg_gain = '0;
    m_reset();
    repeat (2) @(posedge clk); #1;
    chk("rst in_ready", FW'(in_ready), FW'(1));
    chk("rst busy", FW'(busy), FW'(0));
    chk("rst out_valid", FW'(out_valid), FW'(0));
    chk("rst out_frame", out_frame, '0);
    chk("rst cfg_ready", FW'(cfg_ready), FW'(1));
    reset = 1'b0;

    // Echo on ch0
    cfg(0, 3, 128);
    for (int i = 0; i < 10; i++) begin
      sendf((i == 0) ? pk(1000, 0, 0, 0) : '0, "echo");
      chk($sformatf("echo ch0 f%0d", i), FW'(sl(out_frame, 0)), FW'(echo[i]));
    end

    // Reset while idle clears the held output frame
    @(posedge clk); #1; reset = 1'b1; #1;
    chk("idle rst out_frame", out_frame, '0);
    chk("idle rst in_ready", FW'(in_ready), FW'(1));
    chk("idle rst busy", FW'(busy), FW'(0));
    @(posedge clk); #1; reset = 1'b0; m_reset();

    // Saturation on ch1
    cfg(1, 1, 255);
    for (int i = 0; i < 3; i++) begin
      sendf(pk(0, 2000, 0, 0), "satp");
      chk($sformatf("satp ch1 f%0d", i), FW'(sl(out_frame, 1)), FW'((i == 0) ? 2000 : 2047));
    end
    cfg(1, 1, 255);
    for (int i = 0; i < 3; i++) begin
      sendf(pk(0, -2000, 0, 0), "satn");
      chk($sformatf("satn ch1 f%0d", i), FW'(sl(out_frame, 1)), FW'((i == 0) ? -2000 : -2048));
    end

    // Back-to-back frames with in_valid held high
    @(posedge clk); #1;
    in_frame = pk(11, -22, 33, -44); in_valid = 1'b1;
    acc_t = 0; have_acc = 1'b0; nout = 0; viol = 0;
    for (int t = 0; t < 200 && nout < 3; t++) begin
      @(negedge clk);
      if (busy && in_ready) viol++;
      if (out_valid) begin
        chk("b2b latency", FW'(t - acc_t), FW'(17));
        chk("b2b frame", out_frame, sb.pop_front());
        nout++;
        if (nout == 3) in_valid = 1'b0;
      end
      if (in_ready && in_valid) begin
        if (have_acc) chk("b2b spacing", FW'(t - acc_t), FW'(18));
        acc_t = t; have_acc = 1'b1;
        m_frame(in_frame, e);
        sb.push_back(e);
      end
    end
    chk("b2b count", FW'(nout), FW'(3));
    chk("b2b ready while busy", FW'(viol), FW'(0));

    // Stall for 5 cycles at ch2 CALC
    send(pk(5, -6, 7, -8), 11, 5, 0, 0, 0, 0, "stall");

    // Delay 0 behaves as delay 1
    cfg(2, 0, 128);
    for (int i = 0; i < 3; i++) begin
      sendf((i == 0) ? pk(0, 0, 400, 0) : '0, "dly0");
      chk($sformatf("dly0 ch2 f%0d", i), FW'(sl(out_frame, 2)), FW'(400 >>> i));
    end

    // Config while busy is ignored: ch3 keeps gain 0
    send(pk(0, 0, 0, 300), 0, 0, 2, 3, 1, 200, "busycfg");
    sendf(pk(0, 0, 0, 300), "busycfg2");
    chk("busycfg ch3", FW'(sl(out_frame, 3)), FW'(300));

    // Reconfiguring a filled channel must not echo stale RAM
    cfg(2, 3, 128);
    for (int i = 0; i < 4; i++) begin
      sendf((i == 0) ? pk(0, 0, 600, 0) : '0, "recfg");
      chk($sformatf("recfg ch2 f%0d", i), FW'(sl(out_frame, 2)), FW'((i == 0) ? 600 : ((i == 3) ? 300 : 0)));
    end

    // Config and frame on the same edge
    send(pk(0, 100, 0, 0), 0, 0, 1, 1, 1, 128, "simul");
    sendf(pk(0, 100, 0, 0), "simul2");
    chk("simul ch1", FW'(sl(out_frame, 1)), FW'(150));

    // Reset in the middle of a frame
    @(posedge clk); #1; in_frame = pk(1, 2, 3, 4); in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1; reset = 1'b1; #1;
    chk("midrst in_ready", FW'(in_ready), FW'(1));
    chk("midrst busy", FW'(busy), FW'(0));
    @(posedge clk); #1; reset = 1'b0; m_reset();
    n = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("midrst no out_valid", FW'(n), FW'(0));
    chk("midrst idle", FW'(in_ready), FW'(1));

    // Delay 4095 clamps to MAX_LEN
    cfg(3, 4095, 128);
    for (int i = 0; i <= 2048; i++) begin
      sendf((i == 0) ? pk(0, 0, 0, 800) : '0, "clamp");
      if (i == 2047) chk("clamp ch3 f2047", FW'(sl(out_frame, 3)), FW'(0));
      if (i == 2048) chk("clamp ch3 f2048", FW'(sl(out_frame, 3)), FW'(400));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
